sap_obi_arb_n_to_one: RTL and testbench

- Parametrised N-master to 1-slave OBI arbiter with round-robin grant and an ID FIFO for in-order response routing.
- Successor to the fixed-depth varlat N-to-1 crossbar that currently feeds the Safe CPU wrapper CSR path.
- Adds configurable master count, configurable outstanding-transaction depth, address-phase lock, sticky protocol-error detection and an optional response watchdog.
- Sits between the per-hart demux slave[1] ports and the periph_to_reg bridge, or in front of any single OBI slave.

---
 rtl/sap_obi_arb_n_to_one.sv | 188 ++++++++++++++++++
 tb/tb_sap_obi_arb_n_to_one.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_obi_arb_n_to_one.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_obi_arb_n_to_one                                                     |
// | N-master to 1-slave OBI arbiter: round-robin grant, address-phase lock,  |
// | ID FIFO for in-order response routing, sticky protocol-error flag.       |
// | Optional response watchdog enabled by defining SAP_OBI_ARB_WDOG_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package sap_obi_arb_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module sap_obi_arb_n_to_one #(
  parameter type obi_req_t                = sap_obi_arb_pkg::obi_req_t,
  parameter type obi_resp_t               = sap_obi_arb_pkg::obi_resp_t,
  parameter int unsigned NMASTER          = 3,
  parameter int unsigned MAX_OUTSTANDING  = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t  [NMASTER-1:0]              master_req_i,
  output obi_resp_t [NMASTER-1:0]              master_resp_o,
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 proto_err_o,
  output logic                                 timeout_o
);

  localparam int unsigned c_id_w  = $clog2(NMASTER);
  localparam int unsigned c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] c_timeout_rdata = 32'hDEAD_BEEF;

  logic [c_id_w-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0] head_q;
  logic [c_ptr_w-1:0] tail_q;
  logic [c_cnt_w-1:0] count_q;
  logic [c_id_w-1:0]  rr_q;
  logic [c_id_w-1:0]  lock_idx_q;
  logic               lock_q;
  logic               proto_err_q;

  logic [c_id_w-1:0]  w_cand;
  logic [c_id_w-1:0]  w_scan;
  logic [c_id_w-1:0]  w_head_id;
  logic               w_have;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_stall;
  logic               w_rsp_real;
  logic               w_wd_fire;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (count_q == c_cnt_w'(MAX_OUTSTANDING));
  assign w_empty   = (count_q == '0);
  assign w_head_id = fifo_q[head_q];

  // Descending scan so the lowest offset from the pointer is written last and wins.
  always_comb begin
    w_cand = rr_q;
    w_scan = '0;
    w_have = 1'b0;
    if (lock_q) begin
      w_cand = lock_idx_q;
      w_have = 1'b1;
    end else begin
      for (int i = int'(NMASTER) - 1; i >= 0; i--) begin
        w_scan = c_id_w'((int'(rr_q) + i) % int'(NMASTER));
        if (master_req_i[w_scan].req) begin
          w_cand = w_scan;
          w_have = 1'b1;
        end
      end
    end
  end

  // No rvalid term in the gating: a full FIFO never forwards, even while popping.
  always_comb begin
    slave_req_o = '0;
    if (w_have && !rst_i) begin
      slave_req_o     = master_req_i[w_cand];
      slave_req_o.req = master_req_i[w_cand].req & ~w_full;
    end
  end

  assign w_accept   = slave_req_o.req & slave_resp_i.gnt;
  assign w_stall    = slave_req_o.req & ~slave_resp_i.gnt;
  assign w_rsp_real = ~rst_i & slave_resp_i.rvalid & ~w_empty;
  assign w_pop      = w_rsp_real | w_wd_fire;

  always_comb begin
    master_resp_o = '0;
    master_resp_o[w_cand].gnt = slave_resp_i.gnt & slave_req_o.req;
    if (w_pop) begin
      master_resp_o[w_head_id].rvalid = 1'b1;
      master_resp_o[w_head_id].rdata  = w_rsp_real ? slave_resp_i.rdata : c_timeout_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (w_accept) begin
        fifo_q[tail_q] <= w_cand;
        tail_q         <= ptr_inc(tail_q);
        rr_q           <= (w_cand == c_id_w'(NMASTER - 1)) ? '0 : w_cand + 1'b1;
        lock_q         <= 1'b0;
      end else if (w_stall) begin
        lock_q     <= 1'b1;
        lock_idx_q <= w_cand;
      end
      if (w_pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (w_accept && !w_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!w_accept && w_pop) begin
        count_q <= count_q - 1'b1;
      end
      if (slave_resp_i.rvalid && w_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

`ifdef SAP_OBI_ARB_WDOG_EN
  localparam int unsigned c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] wd_cnt_q;
  logic              timeout_q;

  // Counter measures how long the current head has waited; it restarts per head.
  assign w_wd_fire = ~rst_i & ~w_empty & (wd_cnt_q == c_wd_w'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (w_pop || w_empty) begin
        wd_cnt_q <= '0;
      end else if (!w_wd_fire) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (w_wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign w_wd_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_obi_arb_n_to_one.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sap_obi_arb_n_to_one                                                  |
// | Directed scenarios plus random traffic against a transaction-level model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sap_obi_arb_n_to_one;
  import sap_obi_arb_pkg::*;

  localparam int N  = 3;
  localparam int MO = 2;
  localparam int TO = 16;
`ifdef SAP_OBI_ARB_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  obi_req_t  [N-1:0] mreq;
  obi_resp_t [N-1:0] mresp;
  obi_req_t          sreq;
  obi_resp_t         sresp;
  logic [1:0]        outst;
  logic              perr_o;
  logic              tmo_o;

  int checks = 0;
  int errors = 0;

  // Model: queue of master ids awaiting a response, RR pointer, held address phase.
  int q[$];
  int rr = 0;
  int lk_idx = 0;
  int age = 0;
  bit lk = 1'b0;
  bit perr = 1'b0;
  bit tmo = 1'b0;

  int                gnt_idx;
  obi_req_t          sreq_seen;
  obi_resp_t [N-1:0] mresp_seen;

  always #5 clk = ~clk;

  sap_obi_arb_n_to_one #(
    .NMASTER         (N),
    .MAX_OUTSTANDING (MO),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outst),
    .proto_err_o   (perr_o),
    .timeout_o     (tmo_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs applied; checks, advances the model, returns at next negedge.
  task automatic cycle();
    int cand;
    bit have, full, real_rv, fire, pop, acc, was_empty;
    obi_req_t ereq;
    obi_resp_t [N-1:0] eresp;
    #1;
    full = (q.size() == MO);
    have = 1'b0;
    cand = 0;
    if (lk) begin
      have = 1'b1;
      cand = lk_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!have && mreq[(rr + k) % N].req) begin
          have = 1'b1;
          cand = (rr + k) % N;
        end
      end
    end
    ereq = '0;
    if (!rst && have) begin
      ereq     = mreq[cand];
      ereq.req = mreq[cand].req & !full;
    end
    was_empty = (q.size() == 0);
    real_rv = !rst && sresp.rvalid && !was_empty;
    fire    = WD && !rst && !was_empty && (age == TO);
    pop     = real_rv || fire;
    acc     = ereq.req && sresp.gnt;
    eresp = '0;
    if (ereq.req) eresp[cand].gnt = sresp.gnt;
    if (pop) begin
      eresp[q[0]].rvalid = 1'b1;
      eresp[q[0]].rdata  = real_rv ? sresp.rdata : 32'hDEAD_BEEF;
    end
    chk("slave_req", sreq, ereq);
    chk("master_resp", mresp, eresp);
    chk("outstanding", outst, q.size());
    chk("proto_err", perr_o, perr);
    chk("timeout", tmo_o, tmo);
    sreq_seen  = sreq;
    mresp_seen = mresp;
    gnt_idx = -1;
    for (int i = 0; i < N; i++) if (mresp[i].gnt) gnt_idx = i;
    if (rst) begin
      q.delete();
      rr = 0; lk = 1'b0; perr = 1'b0; tmo = 1'b0; age = 0;
    end else begin
      if (sresp.rvalid && was_empty) perr = 1'b1;
      if (fire) tmo = 1'b1;
      if (pop || was_empty) age = 0;
      else if (age < TO) age++;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(cand);
        rr = (cand + 1) % N;
        lk = 1'b0;
      end else if (ereq.req) begin
        lk = 1'b1;
        lk_idx = cand;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int order[$];
    int maxo;
    int acc_cnt;
    int waited;
    bit seen;
    logic [31:0] seen_rdata;

    rst = 1'b1; mreq = '0; sresp = '0;
    @(negedge clk);
    cycle();
    do_reset();
    chk("reset_outstanding", outst, 0);
    chk("reset_resp", mresp, '0);
    chk("reset_sreq_req", sreq.req, 1'b0);

    // All three masters request continuously; zero-wait slave.
    for (int m = 0; m < N; m++) begin
      mreq[m].req = 1'b1; mreq[m].be = 4'hF;
      mreq[m].addr = 32'h1000 * (m + 1); mreq[m].wdata = 32'hC0DE_0000 + m;
    end
    sresp.gnt = 1'b1;
    maxo = 0;
    for (int c = 0; c < 6; c++) begin
      sresp.rvalid = (c > 0);
      sresp.rdata  = 32'hA000_0000 + c;
      cycle();
      order.push_back(gnt_idx);
      if (int'(outst) > maxo) maxo = int'(outst);
    end
    for (int i = 0; i < 6; i++) chk("rr_order", order[i], i % N);
    chk("max_outstanding", maxo, 1);
    mreq = '0; sresp = '0; sresp.rvalid = 1'b1; sresp.rdata = 32'h0BAD_F00D;
    cycle();

    // Rvalid withheld: two accepts then stall; one pop, then one more accept.
    mreq[0].req = 1'b1; mreq[0].addr = 32'h40; mreq[1].req = 1'b1; mreq[1].addr = 32'h44;
    sresp = '0; sresp.gnt = 1'b1;
    acc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (gnt_idx != -1) acc_cnt++;
    end
    chk("accepts_until_full", acc_cnt, 2);
    chk("full_stall_req", sreq.req, 1'b0);
    sresp.rvalid = 1'b1; sresp.rdata = 32'h7777_0001;
    cycle();
    chk("no_accept_on_pop", gnt_idx, -1);
    sresp.rvalid = 1'b0;
    cycle();
    chk("accept_after_pop", gnt_idx != -1, 1'b1);
    chk("refilled", outst, 2);

    // Reset with two outstanding, then contention.
    sresp = '0;
    do_reset();
    chk("post_reset_outstanding", outst, 0);
    chk("post_reset_resp", mresp, '0);
    mreq[2].req = 1'b1; mreq[2].addr = 32'h48;
    sresp.gnt = 1'b1;
    cycle();
    chk("post_reset_winner", gnt_idx, 0);
    mreq = '0; sresp = '0; sresp.rvalid = 1'b1; sresp.rdata = 32'h0000_0042;
    cycle();

    // Address-phase lock while the slave withholds gnt.
    sresp = '0;
    do_reset();
    mreq[1].req = 1'b1; mreq[1].addr = 32'h2222_0000; mreq[1].wdata = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin mreq[0].req = 1'b1; mreq[0].addr = 32'h1111_0000; mreq[0].wdata = 32'h1; end
      cycle();
      chk("lock_addr", sreq_seen.addr, 32'h2222_0000);
      chk("lock_wdata", sreq_seen.wdata, 32'h5555_AAAA);
    end
    sresp.gnt = 1'b1;
    cycle();
    chk("lock_first_grant", gnt_idx, 1);
    mreq[1].req = 1'b0;
    cycle();
    chk("lock_second_grant", gnt_idx, 0);
    mreq = '0; sresp = '0; sresp.rvalid = 1'b1; sresp.rdata = 32'h3333_0001;
    cycle();
    sresp.rdata = 32'h3333_0002;
    cycle();

    // Rvalid with an empty FIFO.
    sresp.rvalid = 1'b1; sresp.rdata = 32'h1234_5678;
    cycle();
    chk("stray_rvalid_dropped", mresp_seen, '0);
    sresp = '0;
    chk("proto_err_set", perr_o, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    chk("proto_err_sticky", perr_o, 1'b1);
    do_reset();
    chk("proto_err_cleared", perr_o, 1'b0);

`ifdef SAP_OBI_ARB_WDOG_EN
    // Hung slave: watchdog answers master 2.
    mreq[2].req = 1'b1; mreq[2].addr = 32'h9000; sresp.gnt = 1'b1;
    cycle();
    mreq = '0; sresp = '0;
    seen = 1'b0; seen_rdata = '0; waited = 0;
    while (!seen && waited < 40) begin
      cycle();
      waited++;
      if (mresp_seen[2].rvalid) begin seen = 1'b1; seen_rdata = mresp_seen[2].rdata; end
    end
    chk("wdog_rvalid", seen, 1'b1);
    chk("wdog_rdata", seen_rdata, 32'hDEAD_BEEF);
    chk("wdog_timeout", tmo_o, 1'b1);
    chk("wdog_outstanding", outst, 0);
    do_reset();
`endif

    // Random traffic: masters hold req until granted; slave gnt/rvalid random.
    mreq = '0; sresp = '0;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < N; m++) begin
        if (!mreq[m].req && ($urandom % 2 == 0)) begin
          mreq[m].req = 1'b1; mreq[m].we = 1'($urandom); mreq[m].be = 4'($urandom);
          mreq[m].addr = $urandom; mreq[m].wdata = $urandom;
        end
      end
      sresp.gnt    = ($urandom % 4 != 0);
      sresp.rvalid = (q.size() > 0) ? 1'($urandom) : ($urandom % 50 == 0);
      sresp.rdata  = $urandom;
      cycle();
      if (gnt_idx >= 0) mreq[gnt_idx].req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
